// File: rtl/spi_dac_multi.sv
`default_nettype none
// ============================================================================
//  Module      : spi_dac_multi
//  Description : Multi-channel SPI DAC transmitter. A sample strobe latches
//                one sample per channel, then one mode-0 MSB-first frame is
//                sent per enabled channel, followed by LDAC strobes issued
//                either once at the end or after every frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_dac_multi #(
    parameter int NCH     = 2,
    parameter int DATA_W  = 8,
    parameter int FRAME_W = 16,
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NCH*DATA_W-1:0] ch_data,
    input  logic [NCH-1:0]        ch_en,
    input  logic                  ldac_mode,
    output logic                  sck,
    output logic                  sdo,
    output logic                  cs_n,
    output logic                  ldac_n,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W = $clog2(FRAME_W);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(FRAME_W - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_GAP   = 3'd3;
    localparam logic [2:0] c_ST_LDAC  = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    generate
        if (FRAME_W < DATA_W + 4 || NCH < 1 || NCH > 16 || CLK_DIV < 1) begin : g_param_check
            $error("spi_dac_multi: illegal parameter combination");
        end
    endgenerate

    // Lowest enabled channel with index >= lo; bit 4 flags that one exists.
    function automatic logic [4:0] f_find(input logic [NCH-1:0] mask, input int lo);
        logic [4:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && i >= lo) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

    // Frame layout: channel index, then sample, then zero padding.
    function automatic logic [FRAME_W-1:0] f_frame(input logic [3:0] idx,
                                                   input logic [DATA_W-1:0] smp);
        logic [FRAME_W-1:0] f;
        f = '0;
        f[FRAME_W-1 -: 4]      = idx;
        f[FRAME_W-5 -: DATA_W] = smp;
        return f;
    endfunction

    logic [2:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_BIT_W-1:0]    r_bit;
    logic                  r_hi;
    logic [3:0]            r_ch;
    logic [FRAME_W-1:0]    r_frame;
    logic [NCH*DATA_W-1:0] r_data;
    logic [NCH-1:0]        r_en;
    logic                  r_mode;

    logic [2:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_BIT_W-1:0]    w_bit_nxt;
    logic                  w_hi_nxt;
    logic [3:0]            w_ch_nxt;
    logic [FRAME_W-1:0]    w_frame_nxt;
    logic                  w_cnt_last;
    logic [4:0]            w_first;
    logic [4:0]            w_next;
    logic [DATA_W-1:0]     w_first_smp;
    logic [DATA_W-1:0]     w_next_smp;

    logic w_sck, w_sdo, w_cs_n, w_ldac_n, w_busy, w_done, w_overrun;

    // The first channel is picked from the live inputs since the shadow copy
    // is only written on the same edge; later channels come from the shadow.
    assign w_cnt_last  = (r_cnt == c_CNT_LAST);
    assign w_first     = f_find(ch_en, 0);
    assign w_next      = f_find(r_en, int'(r_ch) + 1);
    assign w_first_smp = ch_data[int'(w_first[3:0]) * DATA_W +: DATA_W];
    assign w_next_smp  = r_data[int'(w_next[3:0]) * DATA_W +: DATA_W];

    // State register plus sequencing counters and the shadow sample copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_hi    <= 1'b0;
            r_ch    <= '0;
            r_frame <= '0;
            r_data  <= '0;
            r_en    <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_hi    <= w_hi_nxt;
            r_ch    <= w_ch_nxt;
            r_frame <= w_frame_nxt;
            if (r_state == c_ST_IDLE && start) begin
                r_data <= ch_data;
                r_en   <= ch_en;
                r_mode <= ldac_mode;
            end
        end
    end

    // Next-state and counter logic; every timed state lasts whole H-cycle slots.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_hi_nxt    = r_hi;
        w_ch_nxt    = r_ch;
        w_frame_nxt = r_frame;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_cnt_nxt = '0;
                    if (w_first[4]) begin
                        w_state_nxt = c_ST_SETUP;
                        w_ch_nxt    = w_first[3:0];
                        w_frame_nxt = f_frame(w_first[3:0], w_first_smp);
                    end else begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
            end
            c_ST_SETUP: begin
                if (w_cnt_last) begin
                    w_state_nxt = c_ST_SHIFT;
                    w_cnt_nxt   = '0;
                    w_hi_nxt    = 1'b1;
                    w_bit_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_SHIFT: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_hi) begin
                        // SCK falling edge: present the next bit.
                        w_hi_nxt    = 1'b0;
                        w_frame_nxt = {r_frame[FRAME_W-2:0], 1'b0};
                    end else if (r_bit == c_BIT_LAST) begin
                        w_state_nxt = c_ST_GAP;
                    end else begin
                        w_hi_nxt  = 1'b1;
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_GAP: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_mode || !w_next[4]) begin
                        w_state_nxt = c_ST_LDAC;
                    end else begin
                        w_state_nxt = c_ST_SETUP;
                        w_ch_nxt    = w_next[3:0];
                        w_frame_nxt = f_frame(w_next[3:0], w_next_smp);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_LDAC: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (w_next[4]) begin
                        w_state_nxt = c_ST_SETUP;
                        w_ch_nxt    = w_next[3:0];
                        w_frame_nxt = f_frame(w_next[3:0], w_next_smp);
                    end else begin
                        w_state_nxt = c_ST_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered pins line up with it.
    always_comb begin
        w_cs_n    = !(w_state_nxt == c_ST_SETUP || w_state_nxt == c_ST_SHIFT);
        w_sck     = (w_state_nxt == c_ST_SHIFT) && w_hi_nxt;
        w_sdo     = !w_cs_n && w_frame_nxt[FRAME_W-1];
        w_ldac_n  = (w_state_nxt != c_ST_LDAC);
        w_busy    = !(w_state_nxt == c_ST_IDLE || w_state_nxt == c_ST_DONE);
        w_done    = (w_state_nxt == c_ST_DONE);
        w_overrun = start && (r_state != c_ST_IDLE);
    end

    // Output registers; reset drives the idle pin levels immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck     <= 1'b0;
            sdo     <= 1'b0;
            cs_n    <= 1'b1;
            ldac_n  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            sck     <= w_sck;
            sdo     <= w_sdo;
            cs_n    <= w_cs_n;
            ldac_n  <= w_ldac_n;
            busy    <= w_busy;
            done    <= w_done;
            overrun <= w_overrun;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_dac_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_dac_multi
//  Description : Scoreboard bench for spi_dac_multi. Stimulus pushes expected
//                frames and transfer timing; a monitor decodes the SPI pins
//                and pops/compares.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_dac_multi;

    localparam int NCH     = 2;
    localparam int DATA_W  = 8;
    localparam int FRAME_W = 16;
    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] ch_data = '0;
    logic [1:0]  ch_en = '0;
    logic        ldac_mode = 1'b0;
    logic        sck, sdo, cs_n, ldac_n, busy, done, overrun;

    spi_dac_multi #(
        .NCH(NCH), .DATA_W(DATA_W), .FRAME_W(FRAME_W), .CLK_DIV(CLK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ch_data(ch_data), .ch_en(ch_en),
        .ldac_mode(ldac_mode), .sck(sck), .sdo(sdo), .cs_n(cs_n), .ldac_n(ldac_n),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int done_cyc;
        int busy_len;
        int nldac;
    } txn_t;

    logic [15:0] q_frame[$];
    txn_t        q_txn[$];

    int n_chk  = 0;
    int n_pass = 0;
    int exp_ovr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s", name);
    endtask

    // Expected frames and transfer timing relative to the current cycle.
    task automatic push_exp(input int nfr, input logic [15:0] f0, input logic [15:0] f1,
                            input int t, input int nl);
        txn_t x;
        if (nfr >= 1) q_frame.push_back(f0);
        if (nfr >= 2) q_frame.push_back(f1);
        x.done_cyc = cyc + t + 1;
        x.busy_len = t;
        x.nldac    = nl;
        q_txn.push_back(x);
    endtask

    task automatic issue(input logic [15:0] d, input logic [1:0] en, input logic mode,
                         input int nfr, input logic [15:0] f0, input logic [15:0] f1,
                         input int t, input int nl);
        @(negedge clk);
        ch_data = d; ch_en = en; ldac_mode = mode; start = 1'b1;
        push_exp(nfr, f0, f1, t, nl);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (q_txn.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (q_txn.size() != 0) begin
            fail("drain_timeout");
            q_txn.delete();
            q_frame.delete();
        end
    endtask

    // Monitor state
    int          nb = 0, busy_cnt = 0, ldac_cnt = 0, ldac_w = 0, ovr_cnt = 0;
    logic [15:0] cur = '0;
    logic        p_sck = 1'b0, p_cs = 1'b1, p_ldac = 1'b1;

    always @(negedge clk) begin
        logic [15:0] ef;
        txn_t        et;
        if (overrun) ovr_cnt++;
        if (rst) begin
            nb = 0; cur = '0; busy_cnt = 0; ldac_cnt = 0; ldac_w = 0;
        end else begin
            if (sck && !p_sck && !cs_n) begin
                cur = {cur[14:0], sdo};
                nb++;
            end
            if (cs_n && !p_cs) begin
                if (q_frame.size() == 0) begin
                    fail("unexpected_frame");
                end else begin
                    ef = q_frame.pop_front();
                    check("frame", {16'h0, cur}, {16'h0, ef});
                    check("frame_bits", nb, FRAME_W);
                end
                nb = 0; cur = '0;
            end
            if (busy) busy_cnt++;
            if (!ldac_n) begin
                ldac_w++;
                check("ldac_while_cs_high", {31'h0, cs_n}, 32'h1);
                if (p_ldac) ldac_cnt++;
            end else if (!p_ldac) begin
                check("ldac_width", ldac_w, CLK_DIV);
                ldac_w = 0;
            end
            if (done) begin
                if (q_txn.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    et = q_txn.pop_front();
                    check("done_cycle", cyc, et.done_cyc);
                    check("busy_len", busy_cnt, et.busy_len);
                    check("ldac_pulses", ldac_cnt, et.nldac);
                end
                busy_cnt = 0; ldac_cnt = 0;
            end
        end
        p_sck = sck; p_cs = cs_n; p_ldac = ldac_n;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation timed out");
    end

    initial begin
        int k;
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_sck", {31'h0, sck}, 0);
        check("rst_sdo", {31'h0, sdo}, 0);
        check("rst_cs_n", {31'h0, cs_n}, 1);
        check("rst_ldac_n", {31'h0, ldac_n}, 1);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        check("rst_overrun", {31'h0, overrun}, 0);
        @(posedge clk); #3 rst = 1'b0;

        // Basic simultaneous update
        issue(16'h3CA5, 2'b11, 1'b0, 2, 16'h0A50, 16'h13C0, 138, 1);
        wait_drain(400);
        // Staggered update
        issue(16'h3CA5, 2'b11, 1'b1, 2, 16'h0A50, 16'h13C0, 140, 2);
        wait_drain(400);
        // Only channel 1 enabled
        issue(16'h3CA5, 2'b10, 1'b0, 1, 16'h13C0, 16'h0000, 70, 1);
        wait_drain(400);
        // Empty mask
        issue(16'h3CA5, 2'b00, 1'b0, 0, 16'h0000, 16'h0000, 0, 0);
        wait_drain(50);

        // Overrun mid-transfer and in the DONE cycle, then restart right after
        issue(16'h3CA5, 2'b11, 1'b0, 2, 16'h0A50, 16'h13C0, 138, 1);
        repeat (49) @(negedge clk);
        start = 1'b1; ch_data = 16'hFFFF; ch_en = 2'b01; ldac_mode = 1'b1;
        exp_ovr++;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!done) fail("done_wait_timeout");
        start = 1'b1; exp_ovr++;
        @(negedge clk);
        ch_data = 16'h7E81; ch_en = 2'b11; ldac_mode = 1'b0;
        push_exp(2, 16'h0810, 16'h17E0, 138, 1);
        @(negedge clk);
        start = 1'b0;
        wait_drain(400);

        // Input stability: sample changes while its frame is on the wire
        issue(16'h00A5, 2'b01, 1'b0, 1, 16'h0A50, 16'h0000, 70, 1);
        repeat (10) @(negedge clk);
        ch_data = 16'hFFFF;
        wait_drain(400);

        // Reset in the middle of a frame
        @(negedge clk);
        ch_data = 16'h3CA5; ch_en = 2'b11; ldac_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_cs_n", {31'h0, cs_n}, 1);
        check("midrst_sck", {31'h0, sck}, 0);
        check("midrst_ldac_n", {31'h0, ldac_n}, 1);
        check("midrst_busy", {31'h0, busy}, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        issue(16'h3CA5, 2'b11, 1'b0, 2, 16'h0A50, 16'h13C0, 138, 1);
        wait_drain(400);

        repeat (5) @(negedge clk);
        check("frames_left", q_frame.size(), 0);
        check("overrun_pulses", ovr_cnt, exp_ovr);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_dac_multi.md
# spi_dac_multi

Parametrised multi-channel SPI DAC transmitter: the successor to the single-channel 8-bit DAC driver between the wave generator and the external DAC. On a sample strobe it latches one sample per channel and serialises one SPI frame per enabled channel (mode 0, MSB first). It then strobes LDAC either once for all channels (simultaneous update) or after every frame (staggered update). The SCK rate is a parameter derived from `clk`, so no separate divided clock is needed.

## Interface
- `NCH`, 2, number of DAC channels (1..16)
- `DATA_W`, 8, sample width per channel
- `FRAME_W`, 16, SPI frame length in bits; must be at least `DATA_W + 4`
- `CLK_DIV`, 2, `clk` cycles per SCK half-period (≥1); referred to below as H
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle sample strobe
- `ch_data`  in  NCH*DATA_W  samples; channel i occupies bits `[i*DATA_W +: DATA_W]`
- `ch_en`  in  NCH  per-channel enable mask
- `ldac_mode`  in  1  LDAC mode; 0 = one LDAC after the last frame, 1 = LDAC after every frame
- `sck`  out  1  SPI clock; idles low
- `sdo`  out  1  SPI data
- `cs_n`  out  1  chip select, active-low
- `ldac_n`  out  1  DAC latch strobe, active-low
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle completion pulse
- `overrun`  out  1  one-cycle pulse when `start` arrives while `busy`

## Operation
- Reset values:
  - `sck=0`, `sdo=0`, `cs_n=1`, `ldac_n=1`, `busy=0`, `done=0`, `overrun=0`.
  - State returns to IDLE and the shadow registers clear.
- Start acceptance:
  - `start` is accepted only in IDLE. On acceptance, `ch_data`, `ch_en` and `ldac_mode` are latched into shadow registers.
  - Later changes on those inputs do not affect the transfer in progress.
- Frame format, MSB first:
  - Bits `[FRAME_W-1:FRAME_W-4]` carry the 4-bit channel index.
  - The next `DATA_W` bits carry the sample.
  - The remaining bits are zero.
- Channel order: channels are sent in ascending index order. Disabled channels are skipped and produce no CS, SCK or LDAC activity.
- States: IDLE, SETUP, SHIFT, GAP, LDAC, DONE.
  - **IDLE.** On `start` with a nonzero mask, go to SETUP for the lowest enabled channel. With an all-zero mask, go straight to DONE.
  - **SETUP** (H cycles). `cs_n=0`, `sck=0`, `sdo` = frame MSB.
  - **SHIFT** (2*FRAME_W*H cycles). Each bit is H cycles with `sck` high followed by H cycles with `sck` low. `sdo` advances to the next bit on each SCK falling edge, so it is stable across each rising edge.
  - **GAP** (H cycles). `cs_n=1`, `sck=0`.
  - After GAP:
    - If `ldac_mode=1`, or this was the last enabled channel, go to LDAC.
    - Otherwise go to SETUP for the next enabled channel.
  - **LDAC** (H cycles). `ldac_n=0`. Then go to SETUP for the next enabled channel, or to DONE if none remain.
  - **DONE** (1 cycle). `done=1`, `busy=0`. Then return to IDLE.
- `busy` is high in every state except IDLE and DONE.
- Overrun: `start` while `busy=1` is ignored and pulses `overrun` for one cycle. `start` in the DONE cycle is also ignored and flagged.
- Parameter violations (`FRAME_W < DATA_W+4`, `NCH > 16`, `CLK_DIV < 1`) are rejected by an elaboration-time assertion.

## Timing
- `start` sampled high at clock edge 0 → `busy=1`, `cs_n=0` and `sdo`=MSB from cycle 1. Start-to-CS latency is 1 cycle.
- With K = number of enabled channels, `busy` stays high for exactly T cycles:
  - `ldac_mode=0`: T = H*(K*(2*FRAME_W+2)+1)
  - `ldac_mode=1`: T = H*K*(2*FRAME_W+3)
- `done` is high in cycle T+1, after which the block is back in IDLE.
- With K=0, `done` is high in cycle 1 and `busy` never rises.
- `cs_n` stays low for H*(2*FRAME_W+1) cycles per frame and is high for at least H cycles between frames.
- `ldac_n` falls only while `cs_n=1`.
- All outputs are registered, with no combinational path from inputs to outputs.
- `rst` asserted mid-frame forces all outputs to their reset values immediately (asynchronously). No partial LDAC pulse follows reset release.

## Test plan
- **Basic, simultaneous.** NCH=2, DATA_W=8, FRAME_W=16, H=2, `ch_en=2'b11`, `ldac_mode=0`, samples 0xA5 and 0x3C.
  - Frames decode as 0x0A50 and 0x13C0.
  - One `ldac_n` pulse of 2 cycles; `busy` high for 138 cycles; `done` in cycle 139.
- **Staggered.** Same setup with `ldac_mode=1`.
  - Two 2-cycle `ldac_n` pulses, each following its frame's GAP.
  - `busy` high for 140 cycles.
- **Mask.** `ch_en=2'b10`.
  - Only frame 0x13C0 is sent; `busy` high for H*(34+1)=70 cycles.
  - `ch_en=0` → `done` in cycle 1, `cs_n` stays 1.
- **Overrun.** Pulse `start` at cycle 50 of a transfer and again in the DONE cycle.
  - Each produces a 1-cycle `overrun` pulse and the frames are unchanged.
  - A `start` in the first IDLE cycle after DONE is accepted.
- **Input stability.** Change `ch_data` from 0xA5 to 0xFF mid-frame; the transmitted frame remains 0x0A50.
- **Reset mid-frame.** Assert `rst` at cycle 20.
  - Next sample shows `cs_n=1`, `sck=0`, `ldac_n=1`, `busy=0`.
  - After release, a fresh `start` produces a correct full transfer.
